// File: rtl/ascii_line_writer.sv
// Packs an ASCII line stream two chars per word, NUL-terminated, and emits line pointers.
// Optional: ASCII_WRITER_CR_STRIP_EN discards 8'h0D bytes so CRLF packs like LF.
module ascii_line_writer #(
  parameter int         ADDR_W = 10,
  parameter int         LINE_W = 8,
  parameter logic [7:0] EOL    = 8'h0A
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          char_in,
  input  logic                char_valid,
  output logic                char_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [15:0]         mem_din,
  output logic                ptr_we,
  output logic [LINE_W-1:0]   ptr_line,
  output logic [2*ADDR_W-1:0] ptr_addr,
  output logic                overflow
);

  typedef enum logic [1:0] {HI, LO, PTR, DROP} state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] start_word;
  logic [LINE_W-1:0] line_idx;
  logic [7:0]        hi_byte;
  logic              full;
  logic              first;

  logic        acc, is_eol, is_cr;
  logic        wr, do_ptr, bump, ovf_set;
  logic [15:0] wr_data;

  assign char_ready = !rst && (state != PTR);
  assign is_eol     = (char_in == EOL);

`ifdef ASCII_WRITER_CR_STRIP_EN
  assign is_cr = (char_in == 8'h0D);
`else
  assign is_cr = 1'b0;
`endif

  assign acc = char_valid && char_ready && !is_cr;

  always_ff @(posedge clk) begin
    if (rst) state <= HI;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      HI: begin
        if (acc) begin
          if (is_eol) state_n = full ? HI : PTR;
          else        state_n = LO;
        end
      end
      LO: begin
        if (acc) begin
          if (is_eol) state_n = full ? HI : PTR;
          else        state_n = full ? DROP : HI;
        end
      end
      PTR:  state_n = HI;
      DROP: if (acc && is_eol) state_n = HI;
      default: state_n = HI;
    endcase
  end

  // A write attempted into a full store becomes an overflow instead
  always_comb begin
    wr      = 1'b0;
    wr_data = 16'h0000;
    do_ptr  = 1'b0;
    bump    = 1'b0;
    ovf_set = 1'b0;
    unique case (state)
      HI: begin
        if (acc && is_eol) begin
          wr      = !full;
          ovf_set = full;
          bump    = full;
        end
      end
      LO: begin
        if (acc) begin
          wr      = !full;
          ovf_set = full;
          bump    = full && is_eol;
          wr_data = is_eol ? {hi_byte, 8'h00} : {hi_byte, char_in};
        end
      end
      PTR: begin
        do_ptr = 1'b1;
        bump   = 1'b1;
      end
      DROP: bump = acc && is_eol;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr    <= '0;
      start_word <= '0;
      line_idx   <= '0;
      hi_byte    <= 8'h00;
      full       <= 1'b0;
      first      <= 1'b1;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= 16'h0000;
      ptr_we     <= 1'b0;
      ptr_line   <= '0;
      ptr_addr   <= '0;
      overflow   <= 1'b0;
    end else begin
      mem_we <= wr;
      ptr_we <= do_ptr;
      if (state == HI && acc && !is_eol) hi_byte <= char_in;
      if (wr) begin
        mem_addr <= wr_addr;
        mem_din  <= wr_data;
        if (first) begin
          start_word <= wr_addr;
          first      <= 1'b0;
        end
        if (&wr_addr) full    <= 1'b1;
        else          wr_addr <= wr_addr + ADDR_W'(1);
      end
      // mem_addr still holds the NUL word written just before PTR
      if (do_ptr) begin
        ptr_line <= line_idx;
        ptr_addr <= {start_word, mem_addr};
      end
      if (bump) begin
        line_idx <= line_idx + LINE_W'(1);
        first    <= 1'b1;
      end
      if (ovf_set) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ascii_line_writer.sv
// Directed bench for ascii_line_writer: default store and a 4-word store.
module tb_ascii_line_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0;
  logic       sel = 1'b0;
  logic       char_ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  logic        v0, r0, we0, pwe0, ovf0;
  logic [9:0]  a0;
  logic [15:0] d0;
  logic [7:0]  pl0;
  logic [19:0] pa0;

  logic        v1, r1, we1, pwe1, ovf1;
  logic [1:0]  a1;
  logic [15:0] d1;
  logic [7:0]  pl1;
  logic [3:0]  pa1;

  assign v0 = char_valid && !sel;
  assign v1 = char_valid && sel;
  assign char_ready = sel ? r1 : r0;

  ascii_line_writer u0 (
    .clk(clk), .rst(rst), .char_in(char_in), .char_valid(v0),
    .char_ready(r0), .mem_we(we0), .mem_addr(a0), .mem_din(d0),
    .ptr_we(pwe0), .ptr_line(pl0), .ptr_addr(pa0), .overflow(ovf0)
  );

  ascii_line_writer #(.ADDR_W(2)) u1 (
    .clk(clk), .rst(rst), .char_in(char_in), .char_valid(v1),
    .char_ready(r1), .mem_we(we1), .mem_addr(a1), .mem_din(d1),
    .ptr_we(pwe1), .ptr_line(pl1), .ptr_addr(pa1), .overflow(ovf1)
  );

  logic [15:0] cap0 [0:1023];
  logic [15:0] cap1 [0:3];
  int          wc0 = 0, wc1 = 0, pc0 = 0, pc1 = 0, both = 0, low0 = 0;
  logic [7:0]  p0_line = '0;
  logic [19:0] p0_addr = '0;
  logic [3:0]  p1_addr = '0;

  always @(posedge clk) begin
    if (we0) begin cap0[a0] <= d0; wc0 <= wc0 + 1; end
    if (we1) begin cap1[a1] <= d1; wc1 <= wc1 + 1; end
    if (pwe0) begin p0_line <= pl0; p0_addr <= pa0; pc0 <= pc0 + 1; end
    if (pwe1) begin p1_addr <= pa1; pc1 <= pc1 + 1; end
    if ((we0 && pwe0) || (we1 && pwe1)) both <= both + 1;
  end

  always @(negedge clk)
    if (!rst && !sel && !r0) low0 <= low0 + 1;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bit done = 1'b0;
    @(negedge clk);
    char_in = b;
    char_valid = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      if (char_ready) begin
        @(posedge clk);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) check("send_accept", 32'(done), 32'd1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    char_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    char_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int w_snap, p_snap, l_snap;

  initial begin
    repeat (2) @(negedge clk);
    check("ready_in_rst", 32'(r0), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(r0), 32'd1);
    check("rst_ovf", 32'(ovf0), 32'd0);

    // Small store: fill it, then overflow
    sel = 1'b1;
    send_str("abcdef\n");
    idle(3);
    check("s_w0", 32'(cap1[0]), 32'h6162);
    check("s_w1", 32'(cap1[1]), 32'h6364);
    check("s_w2", 32'(cap1[2]), 32'h6566);
    check("s_w3", 32'(cap1[3]), 32'h0000);
    check("s_ptr", 32'(p1_addr), 32'h3);
    check("s_ovf0", 32'(ovf1), 32'd0);
    w_snap = wc1;
    p_snap = pc1;
    send_str("x\n");
    idle(3);
    check("s_ovf1", 32'(ovf1), 32'd1);
    check("s_nowe", 32'(wc1), 32'(w_snap));
    check("s_noptr", 32'(pc1), 32'(p_snap));
    check("s_line", 32'(u1.line_idx), 32'd2);
    send_str("yzw\n");
    idle(3);
    check("s_drop_we", 32'(wc1), 32'(w_snap));
    check("s_drop_ready", 32'(r1), 32'd1);
    check("s_drop_line", 32'(u1.line_idx), 32'd3);
    sel = 1'b0;

    // Default store: three lines
    send_str("ab\n");
    idle(3);
    check("l0_w0", 32'(cap0[0]), 32'h6162);
    check("l0_w1", 32'(cap0[1]), 32'h0000);
    check("l0_pl", 32'(p0_line), 32'd0);
    check("l0_pa", 32'(p0_addr), 32'h00001);
    send_str("abc\n");
    idle(3);
    check("l1_w2", 32'(cap0[2]), 32'h6162);
    check("l1_w3", 32'(cap0[3]), 32'h6300);
    check("l1_pl", 32'(p0_line), 32'd1);
    check("l1_pa", 32'(p0_addr), 32'h00803);
    send(8'h0A);
    #1;
    check("eol_we", 32'(we0), 32'd1);
    check("eol_din", 32'(d0), 32'h0000);
    check("eol_addr", 32'(a0), 32'd4);
    check("eol_ready", 32'(r0), 32'd0);
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    check("ptr_we", 32'(pwe0), 32'd1);
    check("ptr_nowe", 32'(we0), 32'd0);
    check("ptr_ready", 32'(r0), 32'd1);
    check("l2_pl", 32'(pl0), 32'd2);
    check("l2_pa", 32'(pa0), 32'h01004);
    idle(2);

    do_reset();
    check("rr_addr", 32'(a0), 32'd0);
    check("rr_pline", 32'(pl0), 32'd0);
    check("rr_paddr", 32'(pa0), 32'd0);
    check("rr_din", 32'(d0), 32'd0);

    // Back-to-back stream with valid held high
    l_snap = low0;
    p_snap = pc0;
    send_str("ab\ncd\n");
    idle(3);
    check("st_low", 32'(low0 - l_snap), 32'd2);
    check("st_w0", 32'(cap0[0]), 32'h6162);
    check("st_w2", 32'(cap0[2]), 32'h6364);
    check("st_w3", 32'(cap0[3]), 32'h0000);
    check("st_np", 32'(pc0 - p_snap), 32'd2);
    check("st_pa", 32'(p0_addr), 32'h00803);

    do_reset();
    send_str("a\r\n");
    idle(3);
`ifdef ASCII_WRITER_CR_STRIP_EN
    check("cr_w0", 32'(cap0[0]), 32'h6100);
    check("cr_pa", 32'(p0_addr), 32'h00000);
`else
    check("cr_w0", 32'(cap0[0]), 32'h610D);
    check("cr_w1", 32'(cap0[1]), 32'h0000);
    check("cr_pa", 32'(p0_addr), 32'h00001);
`endif

    // Reset in the middle of a line
    do_reset();
    p_snap = pc0;
    send_str("ab");
    do_reset();
    send_str("c\n");
    idle(3);
    check("mr_w0", 32'(cap0[0]), 32'h6300);
    check("mr_np", 32'(pc0 - p_snap), 32'd1);
    check("mr_pl", 32'(p0_line), 32'd0);
    check("mr_pa", 32'(p0_addr), 32'h00000);
    check("mr_ovf", 32'(ovf0), 32'd0);
    check("no_both", 32'(both), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
